// File: rtl/up_counter_multimode.sv
// up_counter_multimode: parametrised up/down/rotate/load/saturating counter with wrap/sat pulses.
// Define UPCTR_WRAP_COUNT_EN to add the saturating 16-bit wrap_cnt output.
module up_counter_multimode #(
    parameter int WIDTH = 8,
    parameter int STEP = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             sat,
`ifdef UPCTR_WRAP_COUNT_EN
    output logic [15:0]      wrap_cnt,
`endif
    output logic             tc
);
    typedef enum logic [2:0] {
        HOLD   = 3'b000,
        INC    = 3'b001,
        DEC    = 3'b010,
        ROL    = 3'b011,
        ROR    = 3'b100,
        LOAD   = 3'b101,
        SATINC = 3'b110,
        CLEAR  = 3'b111
    } mode_e;

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d, sat_q, sat_d;
    logic [WIDTH:0]   sum, diff;

    // Carry and borrow both land in bit WIDTH of the widened result.
    assign sum  = {1'b0, q_q} + STEP_X;
    assign diff = {1'b0, q_q} - STEP_X;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        if (en) begin
            case (mode_e'(mode))
                INC: begin
                    q_d    = sum[WIDTH-1:0];
                    wrap_d = sum[WIDTH];
                end
                DEC: begin
                    q_d    = diff[WIDTH-1:0];
                    wrap_d = diff[WIDTH];
                end
                ROL:    q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                ROR:    q_d = {q_q[0], q_q[WIDTH-1:1]};
                LOAD:   q_d = load_val;
                SATINC: begin
                    q_d   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                    sat_d = sum[WIDTH];
                end
                CLEAR:  q_d = RESET_VAL;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q    <= RESET_VAL;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

`ifdef UPCTR_WRAP_COUNT_EN
    logic [15:0] wrap_cnt_q, wrap_cnt_d;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (en && mode_e'(mode) == CLEAR)
            wrap_cnt_d = '0;
        else if (wrap_d && wrap_cnt_q != 16'hFFFF)
            wrap_cnt_d = wrap_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            wrap_cnt_q <= '0;
        else
            wrap_cnt_q <= wrap_cnt_d;
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

    assign q    = q_q;
    assign wrap = wrap_q;
    assign sat  = sat_q;
    assign tc   = (q_q == '1);
endmodule

// File: tb/tb_up_counter_multimode.sv
// tb_up_counter_multimode: directed self-checking bench for up_counter_multimode (STEP=1 and STEP=5 instances).
module tb_up_counter_multimode;
    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, DEC = 3'd2, ROL = 3'd3,
                           ROR = 3'd4, LOAD = 3'd5, SATINC = 3'd6, CLEAR = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = HOLD;
    logic [7:0] load_val = '0;
    logic [7:0] q, q5;
    logic       wrap, sat, tc, wrap5, sat5, tc5;
`ifdef UPCTR_WRAP_COUNT_EN
    logic [15:0] wrap_cnt, wrap_cnt5;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    up_counter_multimode #(.WIDTH(8), .STEP(1), .RESET_VAL(8'h00)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
        .q(q), .wrap(wrap), .sat(sat),
`ifdef UPCTR_WRAP_COUNT_EN
        .wrap_cnt(wrap_cnt),
`endif
        .tc(tc)
    );

    up_counter_multimode #(.WIDTH(8), .STEP(5), .RESET_VAL(8'h00)) u_dut5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
        .q(q5), .wrap(wrap5), .sat(sat5),
`ifdef UPCTR_WRAP_COUNT_EN
        .wrap_cnt(wrap_cnt5),
`endif
        .tc(tc5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic [2:0] m, input logic [7:0] lv);
        en = e;
        mode = m;
        load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, then a full INC lap
        rst = 1'b0;
        step(1'b1, INC, 8'h00);
        check("rst_q", q, 8'h00);
        check("rst_wrap", wrap, 0);
        check("rst_sat", sat, 0);
        check("rst_tc", tc, 0);
        rst = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step(1'b1, INC, 8'h00);
            check("inc_q", q, i % 256);
            check("inc_wrap", wrap, (i == 256) ? 1 : 0);
            check("inc_tc", tc, (i == 255) ? 1 : 0);
        end

        // rotate
        step(1'b1, LOAD, 8'h81);
        check("load_q", q, 8'h81);
        step(1'b1, ROL, 8'h00);
        check("rol1_q", q, 8'h03);
        check("rol1_wrap", wrap, 0);
        step(1'b1, ROL, 8'h00);
        check("rol2_q", q, 8'h06);
        step(1'b1, ROR, 8'h00);
        check("ror_q", q, 8'h03);
        check("ror_wrap", wrap, 0);
        step(1'b1, LOAD, 8'hFF);
        step(1'b1, ROL, 8'h00);
        check("rol_ones_q", q, 8'hFF);
        step(1'b1, CLEAR, 8'h00);
        check("clear_q", q, 8'h00);
        step(1'b1, ROR, 8'h00);
        check("ror_zero_q", q, 8'h00);

        // decrement with borrow
        step(1'b1, LOAD, 8'h01);
        step(1'b1, DEC, 8'h00);
        check("dec1_q", q, 8'h00);
        check("dec1_wrap", wrap, 0);
        step(1'b1, DEC, 8'h00);
        check("dec2_q", q, 8'hFF);
        check("dec2_wrap", wrap, 1);
        check("dec2_tc", tc, 1);

        // saturating increment, STEP=5
        step(1'b1, LOAD, 8'hFC);
        check("s5_load_q", q5, 8'hFC);
        step(1'b1, SATINC, 8'h00);
        check("s5_sat1_q", q5, 8'hFF);
        check("s5_sat1_sat", sat5, 1);
        check("s5_sat1_wrap", wrap5, 0);
        step(1'b1, SATINC, 8'h00);
        check("s5_sat2_q", q5, 8'hFF);
        check("s5_sat2_sat", sat5, 1);
        step(1'b1, HOLD, 8'h00);
        check("s5_hold_q", q5, 8'hFF);
        check("s5_hold_sat", sat5, 0);
        step(1'b1, LOAD, 8'hF0);
        step(1'b1, SATINC, 8'h00);
        check("s5_nosat_q", q5, 8'hF5);
        check("s5_nosat_sat", sat5, 0);

        // enable gating and reset mid-sequence
        step(1'b1, LOAD, 8'h10);
        step(1'b1, INC, 8'h00);
        check("en1_q", q, 8'h11);
        step(1'b0, INC, 8'h00);
        check("en0_q", q, 8'h11);
        step(1'b1, INC, 8'h00);
        check("en1b_q", q, 8'h12);
        step(1'b1, LOAD, 8'hFF);
        step(1'b1, INC, 8'h00);
        check("wrap_pulse", wrap, 1);
        step(1'b0, INC, 8'h00);
        check("en0_wrap", wrap, 0);
        check("en0_hold_q", q, 8'h00);
        step(1'b1, LOAD, 8'hFF);
        rst = 1'b0;
        step(1'b1, INC, 8'h00);
        check("midrst_q", q, 8'h00);
        check("midrst_wrap", wrap, 0);
        rst = 1'b1;
        step(1'b1, INC, 8'h00);
        check("postrst_q", q, 8'h01);

`ifdef UPCTR_WRAP_COUNT_EN
        rst = 1'b0;
        step(1'b1, INC, 8'h00);
        rst = 1'b1;
        check("wc_rst", wrap_cnt, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, LOAD, 8'hFF);
            step(1'b1, INC, 8'h00);
            check("wc_count", wrap_cnt, i);
        end
        step(1'b1, CLEAR, 8'h00);
        check("wc_clear", wrap_cnt, 0);
        check("wc_clear_q", q, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
